fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-stage forwarding control: generalised operand forwarding plus load-use hazard detection for the EX stage.
- Tracks in-flight register writes in an internal STAGES-deep shift register.
- Produces per-port bypass selects for NPORTS source operands, and a stall request when the youngest matching producer's result is not yet available.
- Sits beside the ID/EX register and drives the EX operand muxes and the ID/EX stall/bubble logic.

Parameters:
- NPORTS, 2, number of source-operand read ports checked by the consumer in EX.
- STAGES, 2, producer stages tracked after EX; stage 1 = EX/MEM, stage STAGES = last stage before writeback.
- REGW, 5, register index width.
- LATW, 2, width of the producer latency field.
- CNTW, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ex_valid  in  1  instruction in EX is valid
- ex_regwrite  in  1  EX instruction writes a register
- ex_rd  in  REGW  EX destination register
- ex_lat  in  LATW  extra stages before the EX result exists: 0 = ALU, 1 = load, ...
- ex_src  in  NPORTS*REGW  EX source registers; port p at bits [p*REGW +: REGW]
- ex_src_used  in  NPORTS  port p is actually read
- hold  in  1  global freeze, e.g. cache miss
- flush  in  1  discard the EX instruction this cycle
- fwd_sel  out  NPORTS*SELW  per-port select, SELW = $clog2(STAGES+1); 0 = register file, k = stage k
- stall  out  1  hold IF/ID/EX and insert a bubble into stage 1
- stall_count  out  CNTW  saturating count of stall cycles

Behaviour:
- Each stage entry holds valid, regwrite, rd and avail.
  - avail = 1 + min(ex_lat, STAGES-1), captured on entry.
  - The result can be forwarded from stage k only when k >= avail.
- Advance (rising clk, hold=0):
  - stage k+1 <= stage k, for k = 1..STAGES-1; stage STAGES is dropped, because the register file is write-through at writeback.
  - stage 1 <= EX instruction if ex_valid && !stall && !flush; otherwise stage 1 <= bubble (valid=0).
- hold=1: all stages and stall_count frozen. fwd_sel and stall are still computed combinationally from the frozen state.
- Match for port p at stage k: valid && regwrite && rd != 0 && rd == src_p.
- Priority: the youngest stage (lowest k) wins. This generalises ex_mem-over-mem_wb.
- fwd_sel[p]:
  - = k when the winning stage k is available.
  - = 0 when there is no match, port unused, ex_valid=0, or src_p == 0.
- Unavailable winner:
  - The port's stall request = ex_valid && ex_src_used[p] && winning match exists && k < avail.
  - fwd_sel[p] for that port = 0 (don't-care while stalled).
  - An older available match must NOT be used instead.
- stall = OR of all port stall requests, masked by flush (flush=1 -> stall=0).
- stall_count:
  - Increments when stall=1 and hold=0.
  - Saturates at all-ones; no wrap.
- Latency:
  - fwd_sel and stall are combinational, same cycle as the inputs.
  - State updates one cycle later.
  - A load (ex_lat=1) directly followed by a consumer gives exactly one stall cycle, then fwd_sel = 2.
- Reset (asynchronous, immediate):
  - All entries invalid and stall_count = 0, hence fwd_sel = 0 and stall = 0.
  - Reset mid-stall clears the stall immediately.
- Simultaneous events:
  - flush + hold: stages frozen, stall = 0.
  - stall + hold: hold dominates; no bubble insertion, no count.
- ex_lat >= STAGES is clamped to STAGES-1. Such a producer becomes forwardable in the last stage.

Decomposition:
- Shared package fwd_pkg holds:
  - the stage-entry struct (valid, regwrite, rd, avail);
  - the select-width function;
  - the constant FWD_SEL_RF = 0.
- One sub-module, fwd_port_match:
  - Combinational priority search over the stage array for one port.
  - Returns the select and the port's stall request.
  - Instantiated NPORTS times by generate.

Test Plan:
- ALU chain (STAGES=2): add r3 <- r1, then sub src0=r3, ex_lat=0 -> fwd_sel[0]=1, stall=0. Next cycle, consumer of r3 with one independent instruction between -> fwd_sel=2.
- Load-use: lw r5 (ex_lat=1), then add src1=r5 -> stall=1 for one cycle, stage 1 bubble, stall_count=1. Next cycle fwd_sel[1]=2, stall=0.
- Priority: r4 in stage 1 (avail) and stage 2 -> sel=1. Stage-1 r4 from a load (unavail) with stage 2 available -> stall=1, not sel=2.
- r0 and unused ports: src=r0 or ex_src_used=0 matching a stage-1 write -> sel=0, stall=0.
- hold/flush: load-use hazard with hold=1 for 3 cycles -> stage contents unchanged, stall_count unchanged. flush=1 during a hazard -> stall=0 and stage 1 bubble on the next edge.
- Reset/saturation: assert rst mid-stall -> stall=0 and fwd_sel=0 immediately. With CNTW=4, 20 consecutive stall cycles -> stall_count=15.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// Stage entries use fixed-width fields so one struct serves every parameterisation.
package fwd_pkg;

    localparam int unsigned ENTRY_REGW   = 8;
    localparam int unsigned ENTRY_AVAILW = 8;
    localparam int unsigned FWD_SEL_RF   = 0;

    typedef struct packed {
        logic                    valid;
        logic                    regwrite;
        logic [ENTRY_REGW-1:0]   rd;
        logic [ENTRY_AVAILW-1:0] avail;
    } stage_entry_t;

    function automatic int unsigned sel_width(input int unsigned stages);
        return (stages + 1 <= 2) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Priority search of the in-flight producer stages for one EX source operand.
// Returns the bypass select and whether this operand must stall.
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int unsigned STAGES = 2,
    parameter int unsigned REGW   = 5,
    parameter int unsigned SELW   = 2
) (
    input  stage_entry_t [STAGES-1:0] stages,
    input  logic                      ex_valid,
    input  logic [REGW-1:0]           src,
    input  logic                      src_used,
    output logic [SELW-1:0]           sel,
    output logic                      stall_req
);

    logic                    found;
    logic [ENTRY_AVAILW-1:0] win_k;
    logic [ENTRY_AVAILW-1:0] win_avail;
    logic                    active;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        found     = 1'b0;
        win_k     = '0;
        win_avail = '0;
        for (int k = int'(STAGES); k >= 1; k--) begin
            if (stages[k-1].valid && stages[k-1].regwrite &&
                stages[k-1].rd != '0 && stages[k-1].rd == ENTRY_REGW'(src)) begin
                found     = 1'b1;
                win_k     = ENTRY_AVAILW'(k);
                win_avail = stages[k-1].avail;
            end
        end
    end

    assign active    = ex_valid && src_used && (src != '0) && found;
    assign sel       = (active && win_k >= win_avail) ? SELW'(win_k) : SELW'(FWD_SEL_RF);
    assign stall_req = active && (win_k < win_avail);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for the EX stage.
// Tracks in-flight register writes in a STAGES-deep shift register.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned NPORTS = 2,
    parameter int unsigned STAGES = 2,
    parameter int unsigned REGW   = 5,
    parameter int unsigned LATW   = 2,
    parameter int unsigned CNTW   = 16,
    localparam int unsigned SELW  = sel_width(STAGES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic                   ex_regwrite,
    input  logic [REGW-1:0]        ex_rd,
    input  logic [LATW-1:0]        ex_lat,
    input  logic [NPORTS*REGW-1:0] ex_src,
    input  logic [NPORTS-1:0]      ex_src_used,
    input  logic                   hold,
    input  logic                   flush,
    output logic [NPORTS*SELW-1:0] fwd_sel,
    output logic                   stall,
    output logic [CNTW-1:0]        stall_count
);

    stage_entry_t [STAGES-1:0] stage_q, stage_d;
    stage_entry_t              new_entry;
    logic [ENTRY_AVAILW-1:0]   lat_c;
    logic [CNTW-1:0]           stall_count_q, stall_count_d;
    logic [NPORTS-1:0]         port_stall;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        fwd_port_match #(
            .STAGES (STAGES),
            .REGW   (REGW),
            .SELW   (SELW)
        ) u_match (
            .stages    (stage_q),
            .ex_valid  (ex_valid),
            .src       (ex_src[p*REGW +: REGW]),
            .src_used  (ex_src_used[p]),
            .sel       (fwd_sel[p*SELW +: SELW]),
            .stall_req (port_stall[p])
        );
    end

    assign stall       = (|port_stall) && !flush;
    assign stall_count = stall_count_q;

    // Results slower than the pipe is deep become forwardable in the last stage.
    always_comb begin
        if (ENTRY_AVAILW'(ex_lat) > ENTRY_AVAILW'(STAGES - 1)) begin
            lat_c = ENTRY_AVAILW'(STAGES - 1);
        end else begin
            lat_c = ENTRY_AVAILW'(ex_lat);
        end
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.regwrite = ex_regwrite;
        new_entry.rd       = ENTRY_REGW'(ex_rd);
        new_entry.avail    = ENTRY_AVAILW'(1) + lat_c;
    end

    always_comb begin
        stage_d       = stage_q;
        stall_count_d = stall_count_q;
        if (!hold) begin
            for (int k = int'(STAGES) - 1; k >= 1; k--) begin
                stage_d[k] = stage_q[k-1];
            end
            stage_d[0] = (ex_valid && !stall && !flush) ? new_entry : '0;
            if (stall && stall_count_q != '1) begin
                stall_count_d = stall_count_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q       <= '0;
            stall_count_q <= '0;
        end else begin
            stage_q       <= stage_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed table-driven bench for fwd_hazard_unit (NPORTS=2, STAGES=2, CNTW=4).
module tb_fwd_hazard_unit;

    localparam int unsigned NPORTS = 2;
    localparam int unsigned STAGES = 2;
    localparam int unsigned REGW   = 5;
    localparam int unsigned LATW   = 2;
    localparam int unsigned CNTW   = 4;
    localparam int unsigned SELW   = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   ex_valid = 1'b0;
    logic                   ex_regwrite = 1'b0;
    logic [REGW-1:0]        ex_rd = '0;
    logic [LATW-1:0]        ex_lat = '0;
    logic [NPORTS*REGW-1:0] ex_src = '0;
    logic [NPORTS-1:0]      ex_src_used = '0;
    logic                   hold = 1'b0;
    logic                   flush = 1'b0;
    logic [NPORTS*SELW-1:0] fwd_sel;
    logic                   stall;
    logic [CNTW-1:0]        stall_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .NPORTS (NPORTS),
        .STAGES (STAGES),
        .REGW   (REGW),
        .LATW   (LATW),
        .CNTW   (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_regwrite (ex_regwrite),
        .ex_rd       (ex_rd),
        .ex_lat      (ex_lat),
        .ex_src      (ex_src),
        .ex_src_used (ex_src_used),
        .hold        (hold),
        .flush       (flush),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_count (stall_count)
    );

    typedef struct {
        int v, rw, rd, lat, s0, s1, used, hd, fl;
        int e0, e1, est, ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int v, int rw, int rd, int lat, int s0, int s1, int used,
                                int hd, int fl, int e0, int e1, int est, int ecnt);
        vec_t r;
        r.v = v; r.rw = rw; r.rd = rd; r.lat = lat; r.s0 = s0; r.s1 = s1; r.used = used;
        r.hd = hd; r.fl = fl; r.e0 = e0; r.e1 = e1; r.est = est; r.ecnt = ecnt;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t r);
        ex_valid    = r.v[0];
        ex_regwrite = r.rw[0];
        ex_rd       = r.rd[REGW-1:0];
        ex_lat      = r.lat[LATW-1:0];
        ex_src      = {r.s1[REGW-1:0], r.s0[REGW-1:0]};
        ex_src_used = r.used[NPORTS-1:0];
        hold        = r.hd[0];
        flush       = r.fl[0];
    endtask

    initial begin
        //            v rw rd lat s0 s1 us hd fl | e0 e1 st cnt
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // after reset
        vecs.push_back(mk(1, 1, 3, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0));   // add r3
        vecs.push_back(mk(1, 1, 6, 0, 3, 1, 3, 0, 0, 1, 0, 0, 0));   // r3 from stage 1
        vecs.push_back(mk(1, 1, 8, 0, 7, 3, 3, 0, 0, 0, 2, 0, 0));   // r3 from stage 2
        vecs.push_back(mk(1, 1, 5, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0));   // lw r5
        vecs.push_back(mk(1, 1, 9, 0, 8, 5, 3, 0, 0, 2, 0, 1, 0));   // load-use stall
        vecs.push_back(mk(1, 1, 9, 0, 9, 5, 3, 0, 0, 0, 2, 0, 1));   // bubble, r5 stage 2
        vecs.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 4, 0, 9, 0, 1, 0, 0, 2, 0, 0, 1));
        vecs.push_back(mk(1, 1, 10, 0, 4, 4, 3, 0, 0, 1, 1, 0, 1)); // r4 in both: youngest
        vecs.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));  // lw r4 over add r4
        vecs.push_back(mk(1, 1, 11, 0, 4, 0, 1, 0, 0, 0, 0, 1, 1)); // no older fallback
        vecs.push_back(mk(1, 1, 11, 0, 4, 0, 1, 0, 0, 2, 0, 0, 2));
        vecs.push_back(mk(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
        vecs.push_back(mk(1, 1, 0, 1, 12, 0, 2, 0, 0, 0, 0, 0, 2)); // unused port, src r0
        vecs.push_back(mk(1, 0, 13, 0, 0, 0, 3, 0, 0, 0, 0, 0, 2)); // r0 write in stage 1
        vecs.push_back(mk(1, 1, 5, 1, 13, 0, 1, 0, 0, 0, 0, 0, 2)); // non-writing producer
        vecs.push_back(mk(1, 1, 14, 0, 5, 0, 1, 1, 0, 0, 0, 1, 2)); // hold x3
        vecs.push_back(mk(1, 1, 14, 0, 5, 0, 1, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 1, 14, 0, 5, 0, 1, 1, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 1, 14, 0, 5, 0, 1, 0, 0, 0, 0, 1, 2));
        vecs.push_back(mk(1, 1, 6, 1, 5, 0, 1, 0, 0, 2, 0, 0, 3));
        vecs.push_back(mk(1, 1, 7, 0, 0, 6, 2, 0, 1, 0, 0, 0, 3));  // flush masks stall
        vecs.push_back(mk(1, 1, 7, 1, 7, 6, 3, 0, 0, 0, 2, 0, 3));  // flushed r7 not seen
        vecs.push_back(mk(1, 1, 15, 0, 7, 0, 1, 1, 1, 0, 0, 0, 3)); // flush + hold
        vecs.push_back(mk(1, 1, 15, 0, 7, 0, 1, 0, 0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 1, 9, 3, 7, 0, 1, 0, 0, 2, 0, 0, 4));  // lat 3 clamped
        vecs.push_back(mk(1, 1, 16, 0, 9, 0, 1, 0, 0, 0, 0, 1, 4));
        vecs.push_back(mk(1, 1, 9, 0, 9, 0, 1, 0, 0, 2, 0, 0, 5));
        vecs.push_back(mk(0, 1, 9, 0, 9, 9, 3, 0, 0, 0, 0, 0, 5));  // ex_valid low

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #3;
            check("sel0", i, int'(fwd_sel[SELW-1:0]), vecs[i].e0);
            check("sel1", i, int'(fwd_sel[2*SELW-1:SELW]), vecs[i].e1);
            check("stall", i, int'(stall), vecs[i].est);
            check("stall_count", i, int'(stall_count), vecs[i].ecnt);
            @(posedge clk);
            #1;
        end

        // Reset asserted in the middle of a load-use stall.
        apply(mk(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        apply(mk(1, 1, 6, 0, 5, 5, 3, 0, 0, 0, 0, 0, 0));
        #2;
        check("pre_rst_stall", 100, int'(stall), 1);
        rst = 1'b1;
        #1;
        check("rst_stall", 101, int'(stall), 0);
        check("rst_sel", 102, int'(fwd_sel), 0);
        check("rst_count", 103, int'(stall_count), 0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back dependent loads stall every other cycle: 20 stalls saturate at 15.
        apply(mk(1, 1, 5, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        repeat (41) @(posedge clk);
        #1;
        check("sat_count", 104, int'(stall_count), 15);
        repeat (2) @(posedge clk);
        #1;
        check("sat_hold", 105, int'(stall_count), 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
